demux_frame_sequencer: RTL and testbench
========================================

// Module: demux_frame_sequencer
// PURPOSE
//   Upstream driver for the 1-to-4 demultiplexer. Accepts a 4-bit word over a valid/ready
//   handshake and serialises it onto the demux inputs D/S1/S0/EN, one channel slot per bit.
//   Bit i of the word is therefore delivered to demux output Yi. Busy and frame-done
//   status are reported to the controlling logic.
// PARAMETERS
//   HOLD_CYCLES  1  clock cycles each channel slot is held; legal range >= 1; 0 is an elaboration error
//   MSB_FIRST    0  0: slots run ch0->ch3; 1: slots run ch3->ch0
// PORTS
//   clk         in   1  single clock; all state updates on rising edge
//   rst_n       in   1  asynchronous, active-low reset
//   din         in   4  word to distribute; din[i] goes to channel i
//   din_valid   in   1  din is valid this cycle
//   din_ready   out  1  sequencer can accept a word this cycle
//   S1, S0      out  1  demux channel select; {S1,S0} = current channel index
//   EN          out  1  demux enable; 1 only during a channel slot
//   D           out  1  demux data; equals buffered bit of current channel, else 0
//   busy        out  1  frame in progress (state != IDLE)
//   frame_done  out  1  one-cycle pulse after the last slot of a frame
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE. S1=S0=EN=D=busy=frame_done=0.
//     din_ready=1 from the first edge after release. Any partial frame is discarded.
//   - All outputs are registered or decoded from registered state only; nothing is combinational from din/din_valid.
//   - States: IDLE -> SLOT -> (GAP, only with macro) -> IDLE.
//   - IDLE: din_ready=1, EN=0, S=00, D=0. On din_valid&&din_ready, latch din into buf.
//     Load ch_idx=0 (3 if MSB_FIRST) and hold_cnt=0; next state SLOT.
//   - SLOT: EN=1, {S1,S0}=ch_idx, D=buf[ch_idx]. hold_cnt counts 0..HOLD_CYCLES-1.
//     On wrap, ch_idx steps +1 (or -1 if MSB_FIRST). Frame is 4*HOLD_CYCLES cycles long.
//   - Latency: word accepted at edge k; first slot is visible on the outputs after edge k.
//   - Last cycle of last slot: din_ready=1 (macro off). If a word is accepted there, the next
//     frame's first slot follows immediately, giving zero bubble. Otherwise the next state is IDLE.
//   - frame_done pulses for exactly 1 cycle, in the cycle after the last slot ends.
//     It also pulses in the zero-bubble case, coincident with the next frame's first slot.
//   - din and din_valid are ignored whenever din_ready=0; buf is never modified mid-frame.
//   - ch_idx is 2 bits. It does not wrap past the final channel; the frame ends instead.
//   - din_valid held high continuously: frames run back to back. Word k+1 is sampled in the last cycle of frame k.
//   - rst_n asserted mid-slot: EN and D drop to 0 immediately (async); no frame_done is issued.
// CONFIGURATION
//   DEMUX_SEQ_GAP_EN defined:
//     - After the last slot, insert one GAP cycle with EN=0, S=00, D=0, busy=1, din_ready=0.
//     - frame_done pulses during GAP. Back-to-back frames are separated by GAP plus IDLE.
//     - din_ready is high only in IDLE.
//   DEMUX_SEQ_GAP_EN undefined:
//     - No GAP state.
//     - Zero-bubble acceptance in the last slot cycle as described above.
// STRUCTURE
//   Package demux_seq_pkg:
//     - NUM_CH=4, SEL_W=2.
//     - state_t enum {IDLE, SLOT, GAP}.
//     - Function next_ch(idx, msb_first).
//   Sub-module demux_seq_slot_ctr:
//     - Owns hold_cnt and ch_idx; outputs slot_last and frame_last.
//     - Top level holds the FSM, buf, handshake and output registers.
// TESTING
//   1. Reset, then check all outputs 0 and din_ready=1 one edge after release.
//   2. HOLD_CYCLES=1, din=4'b1011: 4 slots.
//      Expect {S1,S0,D} = 00/1, 01/1, 10/0, 11/1 with EN=1, then frame_done=1 for 1 cycle.
//   3. HOLD_CYCLES=3, MSB_FIRST=1, din=4'b0110.
//      Each of ch3,ch2,ch1,ch0 is held 3 cycles with D=0,1,1,0; busy=1 for 12 cycles.
//   4. din_valid held 1, words 4'hF then 4'h0 (macro off): no EN=0 cycle between frames.
//      Second frame D=0 in all slots; din changes mid-frame have no effect.
//   5. rst_n pulsed low in slot 2 of a frame: EN=D=0 immediately, no frame_done.
//      After release, the next word runs a full frame from ch0.
//   6. DEMUX_SEQ_GAP_EN defined, back-to-back words.
//      Exactly one EN=0 GAP cycle with frame_done=1, then IDLE, then the next frame.

Source files
------------

// File: rtl/demux_seq_pkg.sv
// Shared types and helpers for the demux frame sequencer.
//   NUM_CH  : number of demux channels (one slot per channel per frame)
//   SEL_W   : width of the channel select / channel index
//   state_t : sequencer FSM states
//   next_ch : channel stepping in the configured slot order
package demux_seq_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOT = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] idx,
                                               input logic             msb_first);
    return msb_first ? idx - 1'b1 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/demux_seq_slot_ctr.sv
// Slot timing for the demux frame sequencer.
// Owns the per-slot hold counter and the current channel index.
//   clk, rst_n  : clock, async active-low reset
//   load        : start a new frame (first channel, hold count 0); wins over adv
//   adv         : a slot cycle is in progress, advance the timing
//   ch_idx      : current channel index
//   slot_last   : last hold cycle of the current slot
//   frame_last  : last hold cycle of the final channel of the frame
module demux_seq_slot_ctr
  import demux_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             adv,
  output logic [SEL_W-1:0] ch_idx,
  output logic             slot_last,
  output logic             frame_last
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [SEL_W-1:0] FIRST_CH = MSB_FIRST ? SEL_W'(NUM_CH-1) : '0;
  localparam logic [SEL_W-1:0] LAST_CH  = MSB_FIRST ? '0 : SEL_W'(NUM_CH-1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HOLD_CYCLES-1);

  generate
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("demux_seq_slot_ctr: HOLD_CYCLES must be >= 1");
    end
  endgenerate

  logic [CNT_W-1:0] hold_cnt;

  assign slot_last  = (hold_cnt == CNT_MAX);
  assign frame_last = slot_last && (ch_idx == LAST_CH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      ch_idx   <= '0;
    end else if (load) begin
      hold_cnt <= '0;
      ch_idx   <= FIRST_CH;
    end else if (adv) begin
      if (slot_last) begin
        hold_cnt <= '0;
        // The index parks on the final channel; the FSM ends the frame there.
        if (!frame_last) ch_idx <= next_ch(ch_idx, MSB_FIRST);
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_frame_sequencer.sv
// Upstream driver for a 1-to-4 demultiplexer. Accepts a 4-bit word on a
// valid/ready handshake and plays it out one channel slot per bit, so bit i
// lands on demux output Yi.
//   clk, rst_n        : clock, async active-low reset
//   din, din_valid    : word to distribute and its valid
//   din_ready         : a word can be accepted this cycle
//   S1, S0, EN, D     : demux select, enable and data
//   busy              : frame in progress
//   frame_done        : one-cycle pulse after the last slot of a frame
// Parameters: HOLD_CYCLES (cycles per slot, >= 1), MSB_FIRST (slot order).
// Optional feature macro DEMUX_SEQ_GAP_EN: adds one idle GAP cycle after each
// frame (frame_done pulses there) and restricts acceptance to IDLE. Without it
// a word can be accepted in the last slot cycle for zero-bubble streaming.
module demux_frame_sequencer
  import demux_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       S1,
  output logic       S0,
  output logic       EN,
  output logic       D,
  output logic       busy,
  output logic       frame_done
);

  state_t            state, state_nxt;
  logic [NUM_CH-1:0] word_q;
  logic [SEL_W-1:0]  ch_idx;
  logic              slot_last, frame_last;
  logic              load, accept, in_slot, frame_end;
  logic              rdy_en;
  logic              frame_done_q;

  demux_seq_slot_ctr #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .MSB_FIRST   (MSB_FIRST)
  ) u_slot_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .adv        (in_slot),
    .ch_idx     (ch_idx),
    .slot_last  (slot_last),
    .frame_last (frame_last)
  );

  assign in_slot   = (state == SLOT);
  // frame_last already implies slot_last; both are named for readability.
  assign frame_end = in_slot && slot_last && frame_last;

  // rdy_en keeps din_ready low while in reset and through the release cycle.
`ifdef DEMUX_SEQ_GAP_EN
  assign din_ready = rdy_en && (state == IDLE);
`else
  assign din_ready = rdy_en && ((state == IDLE) || frame_end);
`endif
  assign accept = din_valid && din_ready;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load      = 1'b1;
          state_nxt = SLOT;
        end
      end
      SLOT: begin
        if (frame_end) begin
`ifdef DEMUX_SEQ_GAP_EN
          state_nxt = GAP;
`else
          if (accept) begin
            load      = 1'b1;
            state_nxt = SLOT;
          end else begin
            state_nxt = IDLE;
          end
`endif
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      word_q       <= '0;
      rdy_en       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      rdy_en       <= 1'b1;
      frame_done_q <= frame_end;
      if (load) word_q <= din;
    end
  end

  // Outputs decode registered state only; EN/D fall with an async reset.
  assign EN         = in_slot;
  assign {S1, S0}   = in_slot ? ch_idx : '0;
  assign D          = in_slot && word_q[ch_idx];
  assign busy       = (state != IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_demux_frame_sequencer.sv
module tb_demux_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din_a = '0, din_b = '0;
  logic       vld_a = 1'b0, vld_b = 1'b0;
  logic       rdy_a, s1_a, s0_a, en_a, d_a, busy_a, fd_a;
  logic       rdy_b, s1_b, s0_b, en_b, d_b, busy_b, fd_b;

  always #5 clk = ~clk;

  // u_a: HOLD_CYCLES=1, LSB first. u_b: HOLD_CYCLES=3, MSB first.
  demux_frame_sequencer #(.HOLD_CYCLES(1), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .din_valid(vld_a), .din_ready(rdy_a),
    .S1(s1_a), .S0(s0_a), .EN(en_a), .D(d_a), .busy(busy_a), .frame_done(fd_a));

  demux_frame_sequencer #(.HOLD_CYCLES(3), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(vld_b), .din_ready(rdy_b),
    .S1(s1_b), .S0(s0_b), .EN(en_b), .D(d_b), .busy(busy_b), .frame_done(fd_b));

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

`ifdef DEMUX_SEQ_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  // Reference model: list of frames (start cycle, word) plus the earliest
  // cycle at which another word may be taken.
  int         fs[$];
  logic [3:0] fw[$];
  int         free_at = 0;

  function automatic void model_clear();
    fs.delete();
    fw.delete();
    free_at = 0;
  endfunction

  function automatic void model_accept(int c, logic [3:0] w, int h);
    fs.push_back(c + 1);
    fw.push_back(w);
    free_at = GAP_ON ? (c + 1 + 4*h + 1) : (c + 1 + 4*h - 1);
  endfunction

  // Expected {din_ready, busy, EN, S1, S0, D, frame_done} in cycle c.
  function automatic logic [6:0] model_out(int c, int h, bit msb);
    logic       rdy, bsy, en, d, fd;
    logic [1:0] s;
    int         k, ch;
    rdy = (c >= free_at);
    bsy = 1'b0; en = 1'b0; d = 1'b0; fd = 1'b0; s = 2'b00;
    for (int i = 0; i < fs.size(); i++) begin
      if (c >= fs[i] && c < fs[i] + 4*h) begin
        k   = (c - fs[i]) / h;
        ch  = msb ? 3 - k : k;
        bsy = 1'b1;
        en  = 1'b1;
        s   = 2'(ch);
        d   = fw[i][ch];
      end
      if (c == fs[i] + 4*h) begin
        fd = 1'b1;
        if (GAP_ON) bsy = 1'b1;
      end
    end
    return {rdy, bsy, en, s, d, fd};
  endfunction

  // Reset both DUTs; release away from the clock edge, then one edge later
  // the model's cycle 0 starts.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; vld_a = 1'b0; vld_b = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    cyc = 0;
    model_clear();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; vld_a = 1'b1; vld_b = 1'b1; din_a = 4'hF; din_b = 4'hF;
    #1;
    n_chk++;
    if ({rdy_a, busy_a, en_a, s1_a, s0_a, d_a, fd_a} !== 7'b0)
      $display("FAIL reset_a got=%b want=0000000", {rdy_a, busy_a, en_a, s1_a, s0_a, d_a, fd_a});
    else n_pass++;
    n_chk++;
    if ({rdy_b, busy_b, en_b, s1_b, s0_b, d_b, fd_b} !== 7'b0)
      $display("FAIL reset_b got=%b want=0000000", {rdy_b, busy_b, en_b, s1_b, s0_b, d_b, fd_b});
    else n_pass++;
    vld_a = 1'b0; vld_b = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++;
    if ({rdy_a, rdy_b} !== 2'b00) $display("FAIL ready_before_edge got=%b want=00", {rdy_a, rdy_b});
    else n_pass++;
    @(posedge clk); @(negedge clk);
    n_chk++;
    if ({rdy_a, busy_a, en_a, s1_a, s0_a, d_a, fd_a} !== 7'b1000000)
      $display("FAIL ready_after_release_a got=%b want=1000000", {rdy_a, busy_a, en_a, s1_a, s0_a, d_a, fd_a});
    else n_pass++;
    n_chk++;
    if (rdy_b !== 1'b1) $display("FAIL ready_after_release_b got=%b want=1", rdy_b);
    else n_pass++;
    cyc = 0;
    model_clear();
  endtask

  // HOLD=1, LSB first, word 1011.
  task automatic test_lsb_frame();
    logic [6:0] exp, got;
    logic [2:0] tbl [4];
    tbl[0] = 3'b001; tbl[1] = 3'b011; tbl[2] = 3'b100; tbl[3] = 3'b111;
    for (int i = 0; i < 8; i++) begin
      vld_a = (i == 0);
      din_a = (i == 0) ? 4'b1011 : 4'($urandom);
      #1;
      exp = model_out(cyc, 1, 1'b0);
      got = {rdy_a, busy_a, en_a, s1_a, s0_a, d_a, fd_a};
      n_chk++;
      if (got !== exp) $display("FAIL lsb_frame cyc=%0d got=%b want=%b", cyc, got, exp);
      else n_pass++;
      if (i >= 1 && i <= 4) begin
        n_chk++;
        if ({en_a, s1_a, s0_a, d_a} !== {1'b1, tbl[i-1]})
          $display("FAIL lsb_slot%0d got=%b want=%b", i-1, {en_a, s1_a, s0_a, d_a}, {1'b1, tbl[i-1]});
        else n_pass++;
      end
      if (i == 5) begin
        n_chk++;
        if ({en_a, fd_a} !== 2'b01) $display("FAIL lsb_done got=%b want=01", {en_a, fd_a});
        else n_pass++;
      end
      if (vld_a && exp[6]) model_accept(cyc, din_a, 1);
      @(posedge clk); @(negedge clk); cyc++;
    end
    vld_a = 1'b0;
  endtask

  // HOLD=3, MSB first, word 0110: 12 busy slot cycles.
  task automatic test_msb_hold3();
    logic [6:0] exp, got;
    int busy_cnt = 0;
    for (int i = 0; i < 18; i++) begin
      vld_b = (i == 0);
      din_b = (i == 0) ? 4'b0110 : 4'($urandom);
      #1;
      exp = model_out(cyc, 3, 1'b1);
      got = {rdy_b, busy_b, en_b, s1_b, s0_b, d_b, fd_b};
      n_chk++;
      if (got !== exp) $display("FAIL msb_hold3 cyc=%0d got=%b want=%b", cyc, got, exp);
      else n_pass++;
      if (en_b) busy_cnt++;
      if (vld_b && exp[6]) model_accept(cyc, din_b, 3);
      @(posedge clk); @(negedge clk); cyc++;
    end
    vld_b = 1'b0;
    n_chk++;
    if (busy_cnt !== 12) $display("FAIL msb_slot_cycles got=%0d want=12", busy_cnt);
    else n_pass++;
  endtask

  // din_valid held high: F then 0, din toggling mid-frame.
  task automatic test_back_to_back();
    logic [6:0] exp, got;
    int en_low = 0;
    for (int i = 0; i < 14; i++) begin
      vld_a = (i < 8);
      if (i == 0) din_a = 4'hF;
      else if (i == 4 || i == 6) din_a = 4'h0;
      else din_a = 4'($urandom);
      #1;
      exp = model_out(cyc, 1, 1'b0);
      got = {rdy_a, busy_a, en_a, s1_a, s0_a, d_a, fd_a};
      n_chk++;
      if (got !== exp) $display("FAIL back_to_back cyc=%0d got=%b want=%b", cyc, got, exp);
      else n_pass++;
      if (i >= 1 && i <= 8 && !en_a) en_low++;
      if (vld_a && exp[6]) model_accept(cyc, din_a, 1);
      @(posedge clk); @(negedge clk); cyc++;
    end
    vld_a = 1'b0;
    n_chk++;
`ifdef DEMUX_SEQ_GAP_EN
    // frame 1: cycles 1-4, GAP 5, IDLE 6 (accept), frame 2: 7-10
    if (en_low !== 2) $display("FAIL gap_en_low got=%0d want=2", en_low);
    else n_pass++;
`else
    if (en_low !== 0) $display("FAIL no_bubble_en_low got=%0d want=0", en_low);
    else n_pass++;
`endif
  endtask

  // Reset pulse during slot 2, then a full frame from ch0.
  task automatic test_reset_mid();
    logic [6:0] exp, got;
    for (int i = 0; i < 3; i++) begin
      vld_a = (i == 0);
      din_a = 4'b0100;
      @(posedge clk); @(negedge clk);
    end
    #1;
    n_chk++;
    if ({en_a, s1_a, s0_a, d_a} !== 4'b1101) $display("FAIL pre_reset_slot2 got=%b want=1101", {en_a, s1_a, s0_a, d_a});
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({en_a, d_a, fd_a, busy_a} !== 4'b0000) $display("FAIL async_drop got=%b want=0000", {en_a, d_a, fd_a, busy_a});
    else n_pass++;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    cyc = 0;
    model_clear();
    for (int i = 0; i < 8; i++) begin
      vld_a = (i == 0);
      din_a = 4'($urandom);
      #1;
      exp = model_out(cyc, 1, 1'b0);
      got = {rdy_a, busy_a, en_a, s1_a, s0_a, d_a, fd_a};
      n_chk++;
      if (got !== exp) $display("FAIL after_mid_reset cyc=%0d got=%b want=%b", cyc, got, exp);
      else n_pass++;
      if (vld_a && exp[6]) model_accept(cyc, din_a, 1);
      @(posedge clk); @(negedge clk); cyc++;
    end
    vld_a = 1'b0;
  endtask

  task automatic test_random_a();
    logic [6:0] exp, got;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      vld_a = ($urandom_range(0, 2) != 0);
      din_a = 4'($urandom);
      #1;
      exp = model_out(cyc, 1, 1'b0);
      got = {rdy_a, busy_a, en_a, s1_a, s0_a, d_a, fd_a};
      n_chk++;
      if (got !== exp) $display("FAIL random_a cyc=%0d got=%b want=%b", cyc, got, exp);
      else n_pass++;
      if (vld_a && exp[6]) model_accept(cyc, din_a, 1);
      @(posedge clk); @(negedge clk); cyc++;
    end
    vld_a = 1'b0;
  endtask

  task automatic test_random_b();
    logic [6:0] exp, got;
    do_reset();
    for (int i = 0; i < 120; i++) begin
      vld_b = ($urandom_range(0, 3) == 0);
      din_b = 4'($urandom);
      #1;
      exp = model_out(cyc, 3, 1'b1);
      got = {rdy_b, busy_b, en_b, s1_b, s0_b, d_b, fd_b};
      n_chk++;
      if (got !== exp) $display("FAIL random_b cyc=%0d got=%b want=%b", cyc, got, exp);
      else n_pass++;
      if (vld_b && exp[6]) model_accept(cyc, din_b, 3);
      @(posedge clk); @(negedge clk); cyc++;
    end
    vld_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lsb_frame();
    do_reset();
    test_msb_hold3();
    do_reset();
    test_back_to_back();
    do_reset();
    test_reset_mid();
    test_random_a();
    test_random_b();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
